qoa_slice_sequencer: RTL
========================

Name: qoa_slice_sequencer

Overview:
Sequences the QOA sample decoder core over one 64-bit QOA slice: 4-bit scalefactor plus 20 packed 3-bit residuals.
- Accepts the slice as a byte stream.
- Issues one decode command byte per residual to the decoder.
- Waits for each decode to finish and hands the decoded sample downstream over a valid/ready handshake.
- Sits between the SPI byte front end and the decoder core, replacing per-sample host commands with per-slice commands.

Parameters:
SLICE_LEN, 20, residuals per slice (QOA fixed; index counter is 5 bits)
WATCHDOG_CYCLES, 64, max cycles to wait for decoder done (used only with the optional feature)

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
in_valid  in  1  slice byte available
in_byte  in  8  slice byte, MSB-first (byte 0 = slice[63:56])
in_ready  out  1  sequencer accepts a slice byte
dec_cmd_valid  out  1  one-cycle strobe: decoder command present
dec_cmd_byte  out  8  decode command {sf[3:0], qr[2:0], 1'b1}
dec_done  in  1  one-cycle strobe from decoder: sample finished
dec_sample  in  16  decoded signed sample, valid with dec_done
out_valid  out  1  decoded sample available
out_sample  out  16  decoded sample
out_ready  in  1  downstream accepts sample
slice_done  out  1  one-cycle strobe after the last sample of a slice is accepted
busy  out  1  high in any state except IDLE
err  out  1  sticky protocol error flag, cleared only by reset

Behaviour:
- Reset values: in_ready=0, dec_cmd_valid=0, dec_cmd_byte=0, out_valid=0, out_sample=0, slice_done=0, busy=0, err=0. All internal state (shift reg, index, byte count) is cleared. Reset mid-slice discards the slice.
- States: IDLE, LOAD, ISSUE, WAIT_DONE, OUTPUT.
- IDLE: in_ready=1. An in_valid&in_ready handshake shifts the byte in, sets byte count=1 and goes to LOAD.
- LOAD: in_ready=1. Each handshake shifts in_byte into slice[7:0] (left shift by 8). The 8th byte goes to ISSUE with idx=0.
- ISSUE: lasts one cycle with dec_cmd_valid=1, then WAIT_DONE.
  - sf = slice[63:60].
  - qr(idx) = slice[59-3*idx -: 3].
  - The registered dec_cmd_byte holds its value until the next ISSUE.
- WAIT_DONE: on dec_done, register out_sample <= dec_sample, set out_valid=1 and go to OUTPUT.
- OUTPUT: out_valid is held with a stable out_sample until out_ready.
  - On handshake with idx==SLICE_LEN-1: out_valid=0, slice_done pulses next cycle, go to IDLE.
  - Otherwise: idx++ and go to ISSUE.
- Latency:
  - 8th byte accepted at cycle N → dec_cmd_valid at N+1.
  - dec_done at M → out_valid at M+1.
  - out handshake at K → next dec_cmd_valid at K+1.
- in_ready=0 in ISSUE, WAIT_DONE and OUTPUT. in_valid there is ignored and not consumed.
- dec_done outside WAIT_DONE is ignored and sets err=1.
- out_ready held high gives back-to-back samples; throughput is bounded by decoder latency plus 2 cycles.
- No arithmetic on samples; the sequencer passes them through bit-exact.

Optional Feature:
QOA_SEQ_WATCHDOG_EN
- Defined: an 8-bit counter runs in WAIT_DONE and is cleared on entry.
  - If it reaches WATCHDOG_CYCLES without dec_done: set err=1, emit out_sample=16'h0000 with out_valid, and continue in OUTPUT as normal.
  - dec_done in the same cycle as the timeout wins: the real sample is used and err is not set.
- Not defined: WAIT_DONE waits indefinitely. err is set only by a spurious dec_done.

Decomposition:
- Shared package qoa_pkg holds:
  - state encoding enum (IDLE..OUTPUT);
  - QOA_SLICE_LEN=20, QOA_SF_W=4, QOA_QR_W=3;
  - CMD_DECODE_BIT=0;
  - a function building the command byte from sf/qr.
- One sub-module is natural: qoa_slice_buf, the 64-bit shift register with byte load and indexed residual extraction (qr mux).
- The FSM, counters and handshake stay in the top module.

Test Plan:
- Load 64'h5000_0000_0000_0000, decoder model replies dec_done after 10 cycles with samples 1..20, out_ready=1 → twenty commands of 0x51; out_sample 1..20 in order; one slice_done; busy drops after the last sample.
- Load 64'h0E00_0000_0000_0005 → dec_cmd_byte 0x0F for idx0, 0x01 for idx1..18, 0x0B for idx19.
- Hold out_ready=0 for 30 cycles on sample 3 (value 16'h8001) → out_valid and out_sample are stable; no new dec_cmd_valid until the handshake; then the 4th command issues one cycle later.
- Assert in_valid during WAIT_DONE and pulse dec_done in IDLE → byte not consumed (in_ready=0); err=1, and it stays set until reset.
- Assert reset at idx=7 in WAIT_DONE, release, load a new slice → all outputs at reset values; the new slice starts at idx0 with the new sf.
- With QOA_SEQ_WATCHDOG_EN, the decoder never answers at idx=2 → after 64 cycles out_sample=0 and err=1; the sequencer completes the remaining 17 samples normally.

Source files
------------

// File: rtl/qoa_pkg.sv
// qoa_pkg: shared state encoding, field widths and decode-command builder for the QOA slice sequencer.
package qoa_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_DONE, OUTPUT} seq_state_t;

    localparam int QOA_SLICE_LEN  = 20;
    localparam int QOA_SF_W       = 4;
    localparam int QOA_QR_W       = 3;
    localparam int CMD_DECODE_BIT = 0;

    function automatic logic [7:0] qoa_cmd(input logic [QOA_SF_W-1:0] sf, input logic [QOA_QR_W-1:0] qr);
        logic [7:0] c;
        c = {sf, qr, 1'b0};
        c[CMD_DECODE_BIT] = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/qoa_slice_buf.sv
// qoa_slice_buf: 64-bit slice shift register with byte load and residual extraction.
module qoa_slice_buf
    import qoa_pkg::*;
(
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                shift,
    input  logic [7:0]          byte_in,
    input  logic [4:0]          idx,
    output logic [QOA_SF_W-1:0] sf,
    output logic [QOA_QR_W-1:0] qr
);

    logic [63:0] slice, slice_d;
    logic [5:0]  lsb;

    // Fields are taken from the post-shift value so the command can be registered on entry to ISSUE.
    assign slice_d = shift ? {slice[55:0], byte_in} : slice;
    assign lsb     = 6'd57 - 6'd3 * 6'(idx);
    assign sf      = slice_d[63:60];
    assign qr      = slice_d[lsb +: QOA_QR_W];

    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) slice <= '0;
        else            slice <= slice_d;

endmodule

// File: rtl/qoa_slice_sequencer.sv
// qoa_slice_sequencer: loads one 64-bit QOA slice and sequences 20 decoder commands, forwarding each sample.
// Optional decoder-done watchdog enabled by defining QOA_SEQ_WATCHDOG_EN.
module qoa_slice_sequencer
    import qoa_pkg::*;
#(
    parameter int SLICE_LEN       = QOA_SLICE_LEN,
    parameter int WATCHDOG_CYCLES = 64
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        dec_cmd_valid,
    output logic [7:0]  dec_cmd_byte,
    input  logic        dec_done,
    input  logic [15:0] dec_sample,
    output logic        out_valid,
    output logic [15:0] out_sample,
    input  logic        out_ready,
    output logic        slice_done,
    output logic        busy,
    output logic        err
);

    seq_state_t          state, state_nxt;
    logic [2:0]          byte_cnt;
    logic [4:0]          idx, idx_nxt;
    logic [QOA_SF_W-1:0] sf;
    logic [QOA_QR_W-1:0] qr;
    logic                in_hs, out_hs, last_idx, timeout;

    assign in_hs    = in_valid & in_ready;
    assign out_hs   = (state == OUTPUT) & out_ready;
    assign last_idx = idx == 5'(SLICE_LEN - 1);
    assign idx_nxt  = (state == LOAD) ? 5'd0 : (out_hs && !last_idx) ? idx + 5'd1 : idx;

`ifdef QOA_SEQ_WATCHDOG_EN
    logic [7:0] wd_cnt;
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) wd_cnt <= '0;
        else            wd_cnt <= (state == WAIT_DONE) ? wd_cnt + 8'd1 : 8'd0;
    // A real dec_done in the timeout cycle takes priority.
    assign timeout = (state == WAIT_DONE) && !dec_done && (wd_cnt == 8'(WATCHDOG_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    qoa_slice_buf u_buf (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .shift     (in_hs),
        .byte_in   (in_byte),
        .idx       (idx_nxt),
        .sf        (sf),
        .qr        (qr)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            byte_cnt     <= '0;
            in_ready     <= 1'b0;
            dec_cmd_byte <= '0;
            out_sample   <= '0;
            slice_done   <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            byte_cnt     <= in_hs ? ((state == IDLE) ? 3'd1 : byte_cnt + 3'd1) : byte_cnt;
            in_ready     <= (state_nxt == IDLE) || (state_nxt == LOAD);
            dec_cmd_byte <= (state_nxt == ISSUE) ? qoa_cmd(sf, qr) : dec_cmd_byte;
            out_sample   <= (state == WAIT_DONE && dec_done) ? dec_sample : timeout ? 16'h0000 : out_sample;
            slice_done   <= out_hs && last_idx;
            err          <= err | (dec_done && state != WAIT_DONE) | timeout;
        end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = in_hs ? LOAD : IDLE;
            LOAD:      state_nxt = (in_hs && byte_cnt == 3'd7) ? ISSUE : LOAD;
            ISSUE:     state_nxt = WAIT_DONE;
            WAIT_DONE: state_nxt = (dec_done || timeout) ? OUTPUT : WAIT_DONE;
            OUTPUT:    state_nxt = out_ready ? (last_idx ? IDLE : ISSUE) : OUTPUT;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dec_cmd_valid = state == ISSUE;
        out_valid     = state == OUTPUT;
        busy          = state != IDLE;
    end

endmodule
